rr_bus_mux: RTL and testbench



---
 rtl/rr_bus_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 38 +++
 rtl/rr_bus_mux.sv | 77 +++++++
 tb/tb_rr_bus_mux.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_bus_pkg.sv
// Shared types and default sizes for the round-robin bus multiplexer.
// No logic; no latency.
// No flow control of its own.
package rr_bus_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    localparam int N_IN_DEF  = 8;
    localparam int WIDTH_DEF = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: first set req bit scanning base, base+1, ... with wrap.
// Combinational, zero latency.
// No flow control; pure function of req and base.
module rr_priority_pick
    import rr_bus_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    int               cand_int;
    logic [SEL_W-1:0] cand;

    // Walk every offset from base; wrap by subtraction so non-power-of-two N_IN never aliases.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_int = 0;
        cand     = '0;
        for (int k = 0; k < N_IN; k++) begin
            cand_int = int'(base) + k;
            if (cand_int >= N_IN) begin
                cand_int = cand_int - N_IN;
            end
            cand = SEL_W'(cand_int);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bus_mux.sv
// N_IN-to-1 arbitrated mux with a single registered output word (round-robin or fixed priority).
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle while out_ready=1.
// Backpressure: when out_valid && !out_ready all in_ready are 0 and output/pointer hold.
module rr_bus_mux
    import rr_bus_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [N_IN-1:0][WIDTH-1:0]  in_data,
    input  logic [N_IN-1:0]             in_valid,
    output logic [N_IN-1:0]             in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             load_en;
    logic             xfer;
    logic             fixed_mode;

    assign fixed_mode = (arb_mode_t'(mode) == ARB_FIXED);
    // Fixed priority is just the rotating search anchored at channel 0.
    assign base       = fixed_mode ? '0 : rr_ptr;
    // Output register can accept a word if empty or being drained this cycle.
    assign load_en    = !out_valid || out_ready;
    assign xfer       = load_en && found;

    rr_priority_pick #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .base  (base),
        .found (found),
        .idx   (grant)
    );

    // One-hot accept to the granted channel only when a transfer will happen.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    // Output word register and round-robin pointer; load takes precedence over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant];
                out_sel   <= grant;
                if (!fixed_mode) begin
                    rr_ptr <= (grant == SEL_W'(N_IN - 1)) ? '0 : grant + SEL_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: 8x16 default instance plus a 5x8 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_rr_bus_mux;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [7:0][15:0] in_data;
    logic [7:0]       in_valid;
    logic [7:0]       in_ready;
    logic [15:0]      out_data;
    logic [2:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    logic             mode5;
    logic [4:0][7:0]  in_data5;
    logic [4:0]       in_valid5;
    logic [4:0]       in_ready5;
    logic [7:0]       out_data5;
    logic [2:0]       out_sel5;
    logic             out_valid5;
    logic             out_ready5;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rr_bus_mux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_bus_mux #(.N_IN(5), .WIDTH(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode5),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_sel   (out_sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        to_drive();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        mode       = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b0;
        mode5      = 1'b0;
        in_data5   = '0;
        in_valid5  = '0;
        out_ready5 = 1'b0;
        to_drive();
        to_sample();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset.out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0) $display("FAIL reset.out_data got=%h exp=0000", out_data); else pass_cnt++;
        total_cnt++; if (out_sel !== 3'd0) $display("FAIL reset.out_sel got=%0d exp=0", out_sel); else pass_cnt++;
        total_cnt++; if (in_ready !== 8'h00) $display("FAIL reset.in_ready got=%b exp=00000000", in_ready); else pass_cnt++;
        total_cnt++; if (dut.rr_ptr !== 3'd0) $display("FAIL reset.rr_ptr got=%0d exp=0", dut.rr_ptr); else pass_cnt++;
        total_cnt++; if (out_valid5 !== 1'b0) $display("FAIL reset.out_valid5 got=%b exp=0", out_valid5); else pass_cnt++;
        to_drive();
        rst_n = 1'b1;
    endtask

    // Load a word, hold it with out_ready=0, then assert reset between edges.
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i] = 16'hBE00 + 16'(i);
        in_valid  = 8'b0001_0000;
        out_ready = 1'b0;
        to_drive();
        in_valid = '0;
        to_sample();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL reset_mid.loaded_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_sel !== 3'd4) $display("FAIL reset_mid.loaded_sel got=%0d exp=4", out_sel); else pass_cnt++;
        total_cnt++; if (out_data !== 16'hBE04) $display("FAIL reset_mid.loaded_data got=%h exp=be04", out_data); else pass_cnt++;
        total_cnt++; if (dut.rr_ptr !== 3'd5) $display("FAIL reset_mid.loaded_ptr got=%0d exp=5", dut.rr_ptr); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_mid.out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0) $display("FAIL reset_mid.out_data got=%h exp=0000", out_data); else pass_cnt++;
        total_cnt++; if (out_sel !== 3'd0) $display("FAIL reset_mid.out_sel got=%0d exp=0", out_sel); else pass_cnt++;
        total_cnt++; if (dut.rr_ptr !== 3'd0) $display("FAIL reset_mid.rr_ptr got=%0d exp=0", dut.rr_ptr); else pass_cnt++;
        to_drive();
        rst_n = 1'b1;
    endtask

    task automatic test_rr_sweep();
        logic [7:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i] = 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        mode      = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            to_sample();
            exp_rdy = 8'b1 << (k % 8);
            total_cnt++; if (in_ready !== exp_rdy) $display("FAIL rr_sweep.in_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); else pass_cnt++;
            if (k >= 1) begin
                total_cnt++; if (out_valid !== 1'b1) $display("FAIL rr_sweep.out_valid k=%0d got=%b exp=1", k, out_valid); else pass_cnt++;
                total_cnt++; if (out_sel !== 3'((k - 1) % 8)) $display("FAIL rr_sweep.out_sel k=%0d got=%0d exp=%0d", k, out_sel, (k - 1) % 8); else pass_cnt++;
                total_cnt++; if (out_data !== 16'((k - 1) % 8)) $display("FAIL rr_sweep.out_data k=%0d got=%h exp=%0d", k, out_data, (k - 1) % 8); else pass_cnt++;
            end
            to_drive();
        end
        in_valid = '0;
    endtask

    // Build rr_ptr=2 in round-robin, then switch to fixed priority and back.
    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i] = 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        mode      = 1'b0;
        to_drive();
        to_drive();
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            to_sample();
            total_cnt++; if (in_ready !== 8'b0000_0001) $display("FAIL fixed.in_ready k=%0d got=%b exp=00000001", k, in_ready); else pass_cnt++;
            total_cnt++; if (dut.rr_ptr !== 3'd2) $display("FAIL fixed.rr_ptr k=%0d got=%0d exp=2", k, dut.rr_ptr); else pass_cnt++;
            if (k == 0) begin
                total_cnt++; if (out_sel !== 3'd1) $display("FAIL fixed.out_sel_prev got=%0d exp=1", out_sel); else pass_cnt++;
            end else begin
                total_cnt++; if (out_sel !== 3'd0) $display("FAIL fixed.out_sel k=%0d got=%0d exp=0", k, out_sel); else pass_cnt++;
            end
            to_drive();
        end
        mode = 1'b0;
        to_sample();
        total_cnt++; if (in_ready !== 8'b0000_0100) $display("FAIL fixed.resume_rr got=%b exp=00000100", in_ready); else pass_cnt++;
        to_drive();
        to_sample();
        total_cnt++; if (out_sel !== 3'd2) $display("FAIL fixed.resume_sel got=%0d exp=2", out_sel); else pass_cnt++;
        in_valid = '0;
    endtask

    task automatic test_sparse_wrap();
        int exp_g[3] = '{7, 2, 7};
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i] = 16'h0A00 + 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        mode      = 1'b0;
        to_drive();
        to_drive();
        to_drive();
        in_valid = 8'b1000_0100;
        for (int j = 0; j < 3; j++) begin
            to_sample();
            if (j == 0) begin
                total_cnt++; if (dut.rr_ptr !== 3'd3) $display("FAIL sparse.start_ptr got=%0d exp=3", dut.rr_ptr); else pass_cnt++;
            end else begin
                total_cnt++; if (out_sel !== 3'(exp_g[j-1])) $display("FAIL sparse.out_sel j=%0d got=%0d exp=%0d", j, out_sel, exp_g[j-1]); else pass_cnt++;
            end
            total_cnt++; if (in_ready !== (8'b1 << exp_g[j])) $display("FAIL sparse.in_ready j=%0d got=%b exp_idx=%0d", j, in_ready, exp_g[j]); else pass_cnt++;
            to_drive();
        end
        to_sample();
        total_cnt++; if (out_sel !== 3'd7) $display("FAIL sparse.last_sel got=%0d exp=7", out_sel); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0A07) $display("FAIL sparse.last_data got=%h exp=0a07", out_data); else pass_cnt++;
        in_valid = '0;
    endtask

    // Stall after the first word, release, then drain with no requests.
    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i] = 16'h10 * 16'(i) + 16'h5;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        mode      = 1'b0;
        to_drive();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp.out_valid k=%0d got=%b exp=1", k, out_valid); else pass_cnt++;
            total_cnt++; if (out_data !== 16'h0005) $display("FAIL bp.out_data k=%0d got=%h exp=0005", k, out_data); else pass_cnt++;
            total_cnt++; if (out_sel !== 3'd0) $display("FAIL bp.out_sel k=%0d got=%0d exp=0", k, out_sel); else pass_cnt++;
            total_cnt++; if (in_ready !== 8'h00) $display("FAIL bp.in_ready k=%0d got=%b exp=00000000", k, in_ready); else pass_cnt++;
            total_cnt++; if (dut.rr_ptr !== 3'd1) $display("FAIL bp.rr_ptr k=%0d got=%0d exp=1", k, dut.rr_ptr); else pass_cnt++;
            to_drive();
        end
        out_ready = 1'b1;
        to_sample();
        total_cnt++; if (in_ready !== 8'b0000_0010) $display("FAIL bp.release_rdy got=%b exp=00000010", in_ready); else pass_cnt++;
        to_drive();
        in_valid = '0;
        to_sample();
        total_cnt++; if (out_sel !== 3'd1) $display("FAIL bp.resume_sel got=%0d exp=1", out_sel); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0015) $display("FAIL bp.resume_data got=%h exp=0015", out_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 8'h00) $display("FAIL bp.idle_rdy got=%b exp=00000000", in_ready); else pass_cnt++;
        to_drive();
        to_sample();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp.drain_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0015) $display("FAIL bp.drain_data got=%h exp=0015", out_data); else pass_cnt++;
        total_cnt++; if (out_sel !== 3'd1) $display("FAIL bp.drain_sel got=%0d exp=1", out_sel); else pass_cnt++;
        total_cnt++; if (dut.rr_ptr !== 3'd2) $display("FAIL bp.drain_ptr got=%0d exp=2", dut.rr_ptr); else pass_cnt++;
    endtask

    task automatic test_n5();
        do_reset();
        for (int i = 0; i < 5; i++) in_data5[i] = 8'h50 + 8'(i);
        in_valid5  = 5'b11111;
        out_ready5 = 1'b1;
        mode5      = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            to_sample();
            total_cnt++; if (in_ready5 !== (5'b1 << (k % 5))) $display("FAIL n5.in_ready k=%0d got=%b exp_idx=%0d", k, in_ready5, k % 5); else pass_cnt++;
            total_cnt++; if (dut5.rr_ptr !== 3'(k % 5)) $display("FAIL n5.rr_ptr k=%0d got=%0d exp=%0d", k, dut5.rr_ptr, k % 5); else pass_cnt++;
            if (k >= 1) begin
                total_cnt++; if (out_sel5 !== 3'((k - 1) % 5)) $display("FAIL n5.out_sel k=%0d got=%0d exp=%0d", k, out_sel5, (k - 1) % 5); else pass_cnt++;
                total_cnt++; if (out_data5 !== 8'h50 + 8'((k - 1) % 5)) $display("FAIL n5.out_data k=%0d got=%h exp=%h", k, out_data5, 8'h50 + 8'((k - 1) % 5)); else pass_cnt++;
            end
            to_drive();
        end
        in_valid5 = '0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rr_sweep();
        test_fixed_priority();
        test_sparse_wrap();
        test_backpressure();
        test_n5();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
